// File: rtl/manchester_pkg.sv
// Shared types and timing derivations for the Manchester frame decoder.
package manchester_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHunt,
    StReceive,
    StDone
  } state_e;

  localparam int unsigned DefHalfBitCycles = 16;
  localparam int unsigned DefPreambleBits  = 8;
  localparam logic [7:0]  DefPreamble      = 8'hAB;
  localparam int unsigned DefMaxBytes      = 8;

  // Edges closer than 1.5 half-bits to the last mid-bit edge sit on a bit boundary.
  function automatic int unsigned blank_cycles(input int unsigned half_bit);
    return (3 * half_bit) / 2;
  endfunction

  function automatic int unsigned timeout_cycles(input int unsigned half_bit);
    return 3 * half_bit;
  endfunction

endpackage

// File: rtl/manchester_bit_recovery.sv
// Edge detector and blanking-window bit timer; emits one strobe per mid-bit edge
// and an idle-line timeout level.
module manchester_bit_recovery
  import manchester_pkg::*;
#(
  parameter int unsigned HALF_BIT_CYCLES = DefHalfBitCycles
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic digital_in,
  input  logic force_accept,
  input  logic ignore_edges,
  output logic bit_strobe,
  output logic bit_value,
  output logic timeout
);

  localparam int unsigned Blank   = blank_cycles(HALF_BIT_CYCLES);
  localparam int unsigned Timeout = timeout_cycles(HALF_BIT_CYCLES);
  localparam int unsigned TcntW   = $clog2(Timeout + 1);

  logic             d_q, d_d, dd_q, dd_d;
  logic             en_q, en_d;
  logic             strobe_q, strobe_d;
  logic             value_q, value_d;
  logic [TcntW-1:0] tcnt_q, tcnt_d;
  logic             edge_det, accept;

  always_comb begin
    edge_det = d_q ^ dd_q;
    timeout  = (tcnt_q == TcntW'(Timeout));
    // en_q low means this is the first enabled cycle after a hold: stale edges are dropped.
    accept   = edge_det && en_q && !ignore_edges &&
               (force_accept || ((tcnt_q >= TcntW'(Blank)) && !timeout));

    en_d     = enable;
    d_d      = d_q;
    dd_d     = dd_q;
    strobe_d = strobe_q;
    value_d  = value_q;
    tcnt_d   = tcnt_q;
    if (enable) begin
      d_d      = digital_in;
      dd_d     = en_q ? d_q : digital_in;
      strobe_d = accept;
      value_d  = accept ? d_q : value_q;
      if (accept) begin
        tcnt_d = '0;
      end else if (!timeout) begin
        tcnt_d = tcnt_q + TcntW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_q      <= 1'b0;
      dd_q     <= 1'b0;
      en_q     <= 1'b0;
      strobe_q <= 1'b0;
      value_q  <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      d_q      <= d_d;
      dd_q     <= dd_d;
      en_q     <= en_d;
      strobe_q <= strobe_d;
      value_q  <= value_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign bit_strobe = strobe_q;
  assign bit_value  = value_q;

endmodule

// File: rtl/manchester_frame_decoder.sv
// Manchester frame decoder: hunts for a sync word, then stores data bytes in a
// small readable buffer until the line goes idle and the consumer acknowledges.
module manchester_frame_decoder
  import manchester_pkg::*;
#(
  parameter int unsigned                HALF_BIT_CYCLES = DefHalfBitCycles,
  parameter int unsigned                PREAMBLE_BITS   = DefPreambleBits,
  parameter logic [PREAMBLE_BITS-1:0]   PREAMBLE        = PREAMBLE_BITS'(DefPreamble),
  parameter int unsigned                MAX_BYTES       = DefMaxBytes
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           digital_in,
  input  logic                           frame_ack,
  input  logic [$clog2(MAX_BYTES)-1:0]   rd_addr,
  output logic [7:0]                     rd_data,
  output logic                           frame_valid,
  output logic [$clog2(MAX_BYTES+1)-1:0] byte_count,
  output logic                           overflow,
  output logic                           frame_error,
  output logic                           preamble_found,
  output logic                           bit_strobe,
  output logic                           bit_value
);

  localparam int unsigned AddrW = $clog2(MAX_BYTES);
  localparam int unsigned CntW  = $clog2(MAX_BYTES + 1);

  state_e                   state_q, state_d;
  logic [PREAMBLE_BITS-1:0] sync_q, sync_d, sync_shift;
  logic [6:0]               shift_q, shift_d;
  logic [2:0]               bit_idx_q, bit_idx_d;
  logic [CntW-1:0]          count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     ferr_q, ferr_d;
  logic                     timeout;
  logic                     wr_en;
  logic [AddrW-1:0]         wr_addr;
  logic [7:0]               wr_data;
  logic [7:0]               mem_q [MAX_BYTES];

  manchester_bit_recovery #(
    .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
  ) u_bit_recovery (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .digital_in   (digital_in),
    .force_accept (state_q == StIdle),
    .ignore_edges (state_q == StDone),
    .bit_strobe   (bit_strobe),
    .bit_value    (bit_value),
    .timeout      (timeout)
  );

  always_comb begin
    state_d        = state_q;
    sync_d         = sync_q;
    shift_d        = shift_q;
    bit_idx_d      = bit_idx_q;
    count_d        = count_q;
    ovf_d          = ovf_q;
    ferr_d         = ferr_q;
    preamble_found = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = count_q[AddrW-1:0];
    wr_data        = {shift_q, bit_value};
    sync_shift     = {sync_q[PREAMBLE_BITS-2:0], bit_value};

    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (bit_strobe) begin
            sync_d  = PREAMBLE_BITS'(bit_value);
            state_d = StHunt;
          end
        end
        StHunt: begin
          if (timeout) begin
            state_d = StIdle;
          end else if (bit_strobe) begin
            sync_d = sync_shift;
            if (sync_shift == PREAMBLE) begin
              preamble_found = 1'b1;
              shift_d        = '0;
              bit_idx_d      = '0;
              count_d        = '0;
              ovf_d          = 1'b0;
              ferr_d         = 1'b0;
              state_d        = StReceive;
            end
          end
        end
        StReceive: begin
          // Timeout is checked first so an edge coinciding with it is dropped.
          if (timeout) begin
            if (count_q == '0) begin
              state_d = StIdle;
            end else begin
              ferr_d  = (bit_idx_q != 3'd0);
              state_d = StDone;
            end
          end else if (bit_strobe) begin
            shift_d   = wr_data[6:0];
            bit_idx_d = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              if (count_q == CntW'(MAX_BYTES)) begin
                ovf_d = 1'b1;
              end else begin
                wr_en   = 1'b1;
                count_d = count_q + CntW'(1);
              end
            end
          end
        end
        StDone: begin
          if (frame_ack) begin
            count_d = '0;
            ovf_d   = 1'b0;
            ferr_d  = 1'b0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      shift_q   <= '0;
      bit_idx_q <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

  // Buffer contents need no reset: count_q gates every read.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (CntW'(rd_addr) < count_q) begin
      rd_data = mem_q[rd_addr];
    end
  end

  assign frame_valid = (state_q == StDone);
  assign byte_count  = count_q;
  assign overflow    = ovf_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_manchester_frame_decoder.sv
// Self-checking bench: builds Manchester waveforms from bit lists and checks the
// decoder against a sync-word search / byte-slicing reference model.
module tb_manchester_frame_decoder;

  localparam int unsigned HB   = 4;
  localparam int unsigned MAXB = 4;
  localparam int unsigned AW   = $clog2(MAXB);
  localparam int unsigned CW   = $clog2(MAXB + 1);
  localparam logic [7:0]  SYNC = 8'hAB;
  localparam int unsigned LEAD = 4;

  logic          clock = 1'b0;
  logic          reset, enable, digital_in, frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_valid;
  logic [CW-1:0] byte_count;
  logic          overflow, frame_error, preamble_found, bit_strobe, bit_value;

  manchester_frame_decoder #(
    .HALF_BIT_CYCLES (HB),
    .PREAMBLE_BITS   (8),
    .PREAMBLE        (SYNC),
    .MAX_BYTES       (MAXB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .digital_in     (digital_in),
    .frame_ack      (frame_ack),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .frame_valid    (frame_valid),
    .byte_count     (byte_count),
    .overflow       (overflow),
    .frame_error    (frame_error),
    .preamble_found (preamble_found),
    .bit_strobe     (bit_strobe),
    .bit_value      (bit_value)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pf_cnt  = 0;
  int first_edge_cyc   = -1;
  int first_strobe_cyc = -1;
  bit wave[$];
  bit sent[$];
  bit got_bits[$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && enable) begin
      if (bit_strobe) begin
        got_bits.push_back(bit_value);
        if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
      end
      if (preamble_found) pf_cnt++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    digital_in = 1'b0;
    frame_ack  = 1'b0;
    enable     = 1'b1;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic new_frame();
    wave.delete();
    sent.delete();
    got_bits.delete();
    pf_cnt = 0;
    for (int k = 0; k < int'(LEAD); k++) wave.push_back(1'b0);
  endtask

  // IEEE: 1 = low then high, 0 = high then low. jit moves the mid edge; glitch
  // flips the first cycle of the cell (inside the boundary blanking window).
  task automatic add_bit(input bit b, input int jit, input bit glitch);
    int start;
    start = wave.size();
    for (int k = 0; k < int'(HB) + jit; k++) wave.push_back(~b);
    for (int k = 0; k < int'(HB) - jit; k++) wave.push_back(b);
    if (glitch) wave[start] = b;
    sent.push_back(b);
  endtask

  // mode 0: clean, 1: random boundary glitches, 2: +/-1 jitter on even bits
  task automatic add_byte(input logic [7:0] v, input int mode);
    for (int i = 7; i >= 0; i--) begin
      int j;
      bit g;
      j = 0;
      g = 1'b0;
      if (mode == 2 && (sent.size() % 2) == 0) j = int'($urandom_range(2)) - 1;
      if (mode == 1 && $urandom_range(2) == 0) g = 1'b1;
      add_bit(v[i], j, g);
    end
  endtask

  task automatic play(input int pause_at);
    for (int i = 0; i < wave.size(); i++) begin
      if (wave[i] != digital_in && first_edge_cyc < 0) first_edge_cyc = cyc;
      digital_in = wave[i];
      if (i == pause_at) begin
        enable = 1'b0;
        repeat (20) step();
        check("hold.no_timeout", frame_valid, 0);
        enable = 1'b1;
      end
      step();
    end
  endtask

  task automatic check_frame(input string tag, output bit exp_valid);
    int         p, nd, nbytes, rem, exp_count, bad;
    logic [7:0] w, eb;
    p = -1;
    for (int i = 7; i < sent.size() && p < 0; i++) begin
      for (int k = 0; k < 8; k++) w[7-k] = sent[i-7+k];
      if (w == SYNC) p = i;
    end
    nd        = (p < 0) ? 0 : sent.size() - p - 1;
    nbytes    = nd / 8;
    rem       = nd % 8;
    exp_valid = (p >= 0) && (nbytes > 0);
    exp_count = exp_valid ? ((nbytes > int'(MAXB)) ? int'(MAXB) : nbytes) : 0;

    if (exp_valid) begin
      for (int k = 0; k < 40 && !frame_valid; k++) step();
    end else begin
      repeat (40) step();
    end

    bad = 0;
    for (int i = 0; i < got_bits.size() && i < sent.size(); i++)
      if (got_bits[i] != sent[i]) bad++;
    check({tag, ".nbits"}, got_bits.size(), sent.size());
    check({tag, ".bits"}, bad, 0);
    check({tag, ".preamble_found"}, pf_cnt, (p >= 0) ? 1 : 0);
    check({tag, ".frame_valid"}, frame_valid, exp_valid);
    check({tag, ".byte_count"}, byte_count, exp_count);
    check({tag, ".overflow"}, overflow, exp_valid && nbytes > int'(MAXB));
    check({tag, ".frame_error"}, frame_error, exp_valid && rem != 0);
    for (int a = 0; a < int'(MAXB); a++) begin
      eb = 8'h00;
      if (a < exp_count)
        for (int k = 0; k < 8; k++) eb[7-k] = sent[p + 1 + 8*a + k];
      rd_addr = AW'(a);
      #1;
      check($sformatf("%s.rd_data[%0d]", tag, a), rd_data, eb);
    end
    rd_addr = '0;
  endtask

  task automatic ack_and_check(input string tag);
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
    check({tag, ".frame_valid"}, frame_valid, 0);
    check({tag, ".byte_count"}, byte_count, 0);
    check({tag, ".overflow"}, overflow, 0);
    check({tag, ".frame_error"}, frame_error, 0);
    check({tag, ".rd_data"}, rd_data, 0);
  endtask

  task automatic check_all_zero(input string tag);
    rd_addr = '0;
    #1;
    check({tag, ".frame_valid"}, frame_valid, 0);
    check({tag, ".byte_count"}, byte_count, 0);
    check({tag, ".overflow"}, overflow, 0);
    check({tag, ".frame_error"}, frame_error, 0);
    check({tag, ".preamble_found"}, preamble_found, 0);
    check({tag, ".bit_strobe"}, bit_strobe, 0);
    check({tag, ".bit_value"}, bit_value, 0);
    check({tag, ".rd_data"}, rd_data, 0);
  endtask

  initial begin
    bit ev;
    rd_addr   = '0;
    enable    = 1'b1;
    frame_ack = 1'b0;
    do_reset();
    check_all_zero("rst");

    // Basic frame plus bit latency
    new_frame();
    add_byte(SYNC, 0);
    add_byte(8'h3C, 0);
    add_byte(8'h81, 0);
    first_edge_cyc   = -1;
    first_strobe_cyc = -1;
    play(-1);
    check("bit_latency", first_strobe_cyc - first_edge_cyc, 2);
    check_frame("basic", ev);
    ack_and_check("basic.ack");

    // Overflow
    do_reset();
    new_frame();
    add_byte(SYNC, 0);
    for (int b = 1; b <= 6; b++) add_byte(8'(b), 0);
    play(-1);
    check_frame("ovf", ev);
    ack_and_check("ovf.ack");

    // Partial trailing byte
    do_reset();
    new_frame();
    add_byte(SYNC, 0);
    add_byte(8'h5A, 0);
    add_bit(1'b1, 0, 1'b0);
    add_bit(1'b0, 0, 1'b0);
    add_bit(1'b1, 0, 1'b0);
    play(-1);
    check_frame("partial", ev);
    ack_and_check("partial.ack");

    // Boundary glitches, then jitter
    do_reset();
    new_frame();
    add_byte(SYNC, 0);
    add_byte(8'h3C, 1);
    add_byte(8'h81, 1);
    play(-1);
    check_frame("glitch", ev);
    ack_and_check("glitch.ack");
    do_reset();
    new_frame();
    add_byte(SYNC, 0);
    add_byte(8'h3C, 2);
    add_byte(8'h81, 2);
    play(-1);
    check_frame("jitter", ev);
    ack_and_check("jitter.ack");

    // No sync word, then a good frame without reset
    do_reset();
    new_frame();
    for (int k = 0; k < 3; k++) add_byte(8'hAA, 0);
    play(-1);
    check_frame("nosync", ev);
    new_frame();
    add_byte(SYNC, 0);
    add_byte(8'h3C, 0);
    add_byte(8'h81, 0);
    play(-1);
    check_frame("after_nosync", ev);
    ack_and_check("after_nosync.ack");

    // Reset mid-byte in receive
    do_reset();
    new_frame();
    add_byte(SYNC, 0);
    add_byte(8'h3C, 0);
    add_bit(1'b1, 0, 1'b0);
    add_bit(1'b1, 0, 1'b0);
    add_bit(1'b0, 0, 1'b0);
    add_bit(1'b1, 0, 1'b0);
    play(-1);
    check("midrst.pre_count", byte_count, 1);
    reset      = 1'b1;
    digital_in = 1'b0;
    step();
    check_all_zero("midrst");
    reset = 1'b0;
    step();
    new_frame();
    add_byte(SYNC, 0);
    add_byte(8'h81, 0);
    play(-1);
    check_frame("after_rst", ev);
    ack_and_check("after_rst.ack");

    // Enable held low mid-bit (data bit 2 of 0x3C, first half, offset 3)
    do_reset();
    new_frame();
    add_byte(SYNC, 0);
    add_byte(8'h3C, 0);
    add_byte(8'h81, 0);
    play(int'(LEAD) + 10 * 2 * int'(HB) + 3);
    check_frame("hold", ev);
    ack_and_check("hold.ack");

    // Randomised frames
    for (int it = 0; it < 8; it++) begin
      int nb, ex, mode;
      nb   = int'($urandom_range(6));
      ex   = int'($urandom_range(7));
      mode = int'($urandom_range(2));
      do_reset();
      new_frame();
      add_byte(SYNC, 0);
      for (int b = 0; b < nb; b++) add_byte(8'($urandom_range(255)), mode);
      for (int b = 0; b < ex; b++) add_bit(1'($urandom_range(1)), 0, 1'b0);
      play(-1);
      check_frame($sformatf("rnd%0d", it), ev);
      if (ev) ack_and_check($sformatf("rnd%0d.ack", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
